multicycle_control: RTL and testbench

//  Moore/Mealy FSM that sequences a multi-cycle MIPS-subset datapath. It shares a single memory port and ALU across

---
 rtl/multicycle_control_pkg.sv | 59 +++++
 rtl/multicycle_control_opdecode.sv | 33 +++
 rtl/multicycle_control.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared definitions for the multi-cycle MIPS-subset control
//               unit: opcode constants, state encoding (4-bit binary with
//               HALT at 4'hF), ALU operation and ALU B-source codes, and the
//               one-hot opcode decode record.
// Revision    : 1.0  initial release
// ============================================================================
package multicycle_control_pkg;

    // Supported opcodes, taken from IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B-operand source select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_EXEC_R = 4'h2,
        S_EXEC_I = 4'h3,
        S_MEM_RD = 4'h4,
        S_MEM_WR = 4'h5,
        S_WB_R   = 4'h6,
        S_WB_I   = 4'h7,
        S_WB_MEM = 4'h8,
        S_BRANCH = 4'h9,
        S_HALT   = 4'hF
    } state_t;

    // One-hot opcode classification; exactly one field is set
    typedef struct packed {
        logic r_type;
        logic addi;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic bgtz;
        logic illegal;
    } op_dec_t;

endpackage : multicycle_control_pkg
`default_nettype wire

// File: rtl/multicycle_control_opdecode.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_opdecode
// Description : Purely combinational opcode classifier. Maps the 6-bit
//               opcode onto a one-hot record; anything outside the supported
//               subset raises the illegal flag.
// Ports       : opcode  in  6   IR[31:26]
//               dec     out 8   one-hot {r_type,addi,lw,sw,beq,bne,bgtz,illegal}
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_opdecode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    output op_dec_t    dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: dec.r_type  = 1'b1;
            OP_ADDI:  dec.addi    = 1'b1;
            OP_LW:    dec.lw      = 1'b1;
            OP_SW:    dec.sw      = 1'b1;
            OP_BEQ:   dec.beq     = 1'b1;
            OP_BNE:   dec.bne     = 1'b1;
            OP_BGTZ:  dec.bgtz    = 1'b1;
            default:  dec.illegal = 1'b1;
        endcase
    end

endmodule : multicycle_control_opdecode
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Control FSM for a multi-cycle MIPS-subset datapath sharing a
//               single memory port and ALU. Sequences FETCH/DECODE/EXEC/MEM/
//               WB steps, waits on a memory-ready handshake and halts via a
//               watchdog if memory never answers.
// Parameters  : TIMEOUT  cycles to wait for mem_ready before halting
//               TO_W     watchdog width, 2**TO_W > TIMEOUT
// Ports       : clk, rst_n (async active-low)
//               opcode, zero, alu_res_msb, mem_ready        - status inputs
//               pc_wr, pc_src, iord, mem_rd, mem_wr, ir_wr,
//               reg_wr, reg_dst, mem_to_reg, alu_src_a,
//               alu_src_b[1:0], alu_op[1:0], ext_op        - datapath controls
//               illegal_op (pulse), halted (sticky)        - status outputs
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       alu_res_msb,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       pc_src,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic       illegal_op,
    output logic       halted
);

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wdog;
    op_dec_t         dec;
    logic            is_mem_state;
    logic            wdog_expire;

    multicycle_control_opdecode u_opdecode (
        .opcode (opcode),
        .dec    (dec)
    );

    assign is_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    // The counter holds the number of stalled cycles already spent; the
    // current stalled cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
    // A mem_ready in that same cycle takes priority over the timeout.
    assign wdog_expire = is_mem_state && !mem_ready && (wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            // Any exit from a memory state (or the halt) clears the count,
            // so each new memory state starts from zero.
            if (is_mem_state && !mem_ready && !wdog_expire) begin
                wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_wr      = 1'b0;
        pc_src     = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        ext_op     = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                // rst_n qualifies the Mealy enables so nothing is loaded
                // while reset is held, whatever memory reports.
                if (mem_ready && rst_n) begin
                    ir_wr     = 1'b1;
                    pc_wr     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wdog_expire) begin
                    state_nxt = S_HALT;
                end
            end

            S_DECODE: begin
                // Branch target precomputed here while the register file
                // is read.
                alu_src_b = SRCB_IMM_SH2;
                ext_op    = 1'b1;
                if (dec.r_type) begin
                    state_nxt = S_EXEC_R;
                end else if (dec.addi || dec.lw || dec.sw) begin
                    state_nxt = S_EXEC_I;
                end else if (dec.beq || dec.bne || dec.bgtz) begin
                    state_nxt = S_BRANCH;
                end else begin
                    illegal_op = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_nxt = S_WB_R;
            end

            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
                if (dec.lw) begin
                    state_nxt = S_MEM_RD;
                end else if (dec.sw) begin
                    state_nxt = S_MEM_WR;
                end else begin
                    state_nxt = S_WB_I;
                end
            end

            S_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_WB_MEM;
                end else if (wdog_expire) begin
                    state_nxt = S_HALT;
                end
            end

            S_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                end else if (wdog_expire) begin
                    state_nxt = S_HALT;
                end
            end

            S_WB_R: begin
                reg_wr    = 1'b1;
                reg_dst   = 1'b1;
                state_nxt = S_FETCH;
            end

            S_WB_I: begin
                reg_wr    = 1'b1;
                state_nxt = S_FETCH;
            end

            S_WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                state_nxt  = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_wr     = (dec.beq  &  zero) |
                            (dec.bne  & ~zero) |
                            (dec.bgtz & ~zero & ~alu_res_msb);
                state_nxt = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control. Output
//               vector bit order (16..0): pc_wr pc_src iord mem_rd mem_wr
//               ir_wr reg_wr reg_dst mem_to_reg alu_src_a alu_src_b[1:0]
//               alu_op[1:0] ext_op illegal_op halted.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    //                                      pc pcs io mr mw ir rw rd m2r sa  srcb aop ext ill hlt
    localparam logic [16:0] E_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_0_0_0;
    localparam logic [16:0] E_FETCH_GO   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_0_0_0;
    localparam logic [16:0] E_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_1_0_0;
    localparam logic [16:0] E_DECODE_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_1_1_0;
    localparam logic [16:0] E_EXEC_R     = 17'b0_0_0_0_0_0_0_0_0_1_00_10_0_0_0;
    localparam logic [16:0] E_EXEC_I     = 17'b0_0_0_0_0_0_0_0_0_1_10_00_1_0_0;
    localparam logic [16:0] E_MEM_RD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_0_0_0;
    localparam logic [16:0] E_MEM_WR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_0_0_0;
    localparam logic [16:0] E_WB_R       = 17'b0_0_0_0_0_0_1_1_0_0_00_00_0_0_0;
    localparam logic [16:0] E_WB_I       = 17'b0_0_0_0_0_0_1_0_0_0_00_00_0_0_0;
    localparam logic [16:0] E_WB_MEM     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_0_0_0;
    localparam logic [16:0] E_BR_TAKEN   = 17'b1_1_0_0_0_0_0_0_0_1_00_01_0_0_0;
    localparam logic [16:0] E_BR_NOT     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_0_0_0;
    localparam logic [16:0] E_HALT       = 17'b0_0_0_0_0_0_0_0_0_0_00_00_0_0_1;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       alu_res_msb;
    logic       mem_ready;
    logic       pc_wr, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_wr;
    logic       reg_dst, mem_to_reg, alu_src_a, ext_op, illegal_op, halted;
    logic [1:0] alu_src_b, alu_op;
    logic [16:0] obs;

    int passed = 0;
    int total  = 0;

    assign obs = {pc_wr, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, illegal_op, halted};

    multicycle_control #(
        .TIMEOUT (4),
        .TO_W    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .alu_res_msb (alu_res_msb),
        .mem_ready   (mem_ready),
        .pc_wr       (pc_wr),
        .pc_src      (pc_src),
        .iord        (iord),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .ir_wr       (ir_wr),
        .reg_wr      (reg_wr),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .ext_op      (ext_op),
        .illegal_op  (illegal_op),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        mem_ready   = 1'b0;
        opcode      = 6'b0;
        zero        = 1'b0;
        alu_res_msb = 1'b0;
        next_cycle();
        next_cycle();
        total++;
        if (obs !== E_FETCH_WAIT) $display("FAIL reset_state got %b expected %b", obs, E_FETCH_WAIT);
        else passed++;
        // Memory answering while reset is held must not load PC or IR.
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH_WAIT) $display("FAIL reset_ready got %b expected %b", obs, E_FETCH_WAIT);
        else passed++;
        mem_ready = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_r_type();
        logic [16:0] exp [4] = '{E_FETCH_GO, E_DECODE, E_EXEC_R, E_WB_R};
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL r_type cycle %0d got %b expected %b", i, obs, exp[i]);
            else passed++;
            next_cycle();
        end
        #1;
        total++;
        if (obs !== E_FETCH_GO) $display("FAIL r_type_return got %b expected %b", obs, E_FETCH_GO);
        else passed++;
    endtask

    task automatic test_lw_stall();
        logic [16:0] exp [8] = '{E_FETCH_GO, E_DECODE, E_EXEC_I, E_MEM_RD,
                                 E_MEM_RD, E_MEM_RD, E_MEM_RD, E_WB_MEM};
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL lw_stall cycle %0d got %b expected %b", i, obs, exp[i]);
            else passed++;
            next_cycle();
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH_GO) $display("FAIL lw_return got %b expected %b", obs, E_FETCH_GO);
        else passed++;
    endtask

    task automatic test_sw_addi();
        logic [16:0] exp_sw [4] = '{E_FETCH_GO, E_DECODE, E_EXEC_I, E_MEM_WR};
        logic [16:0] exp_ai [4] = '{E_FETCH_GO, E_DECODE, E_EXEC_I, E_WB_I};
        mem_ready = 1'b1;
        opcode    = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== exp_sw[i]) $display("FAIL sw cycle %0d got %b expected %b", i, obs, exp_sw[i]);
            else passed++;
            next_cycle();
        end
        opcode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== exp_ai[i]) $display("FAIL addi cycle %0d got %b expected %b", i, obs, exp_ai[i]);
            else passed++;
            next_cycle();
        end
        #1;
        total++;
        if (obs !== E_FETCH_GO) $display("FAIL addi_return got %b expected %b", obs, E_FETCH_GO);
        else passed++;
    endtask

    task automatic test_branch(input string name, input logic [5:0] op,
                               input logic z, input logic msb, input logic taken);
        logic [16:0] exp [3];
        exp[0] = E_FETCH_GO;
        exp[1] = E_DECODE;
        exp[2] = taken ? E_BR_TAKEN : E_BR_NOT;
        opcode      = op;
        zero        = z;
        alu_res_msb = msb;
        mem_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL %s cycle %0d got %b expected %b", name, i, obs, exp[i]);
            else passed++;
            next_cycle();
        end
        zero        = 1'b0;
        alu_res_msb = 1'b0;
    endtask

    task automatic test_illegal();
        opcode    = 6'b111111;
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH_GO) $display("FAIL illegal_fetch got %b expected %b", obs, E_FETCH_GO);
        else passed++;
        next_cycle();
        #1;
        total++;
        if (obs !== E_DECODE_ILL) $display("FAIL illegal_decode got %b expected %b", obs, E_DECODE_ILL);
        else passed++;
        next_cycle();
        mem_ready = 1'b0;
        #1;
        total++;
        if (obs !== E_FETCH_WAIT) $display("FAIL illegal_next got %b expected %b", obs, E_FETCH_WAIT);
        else passed++;
    endtask

    // Continues in the FETCH cycle left by test_illegal, watchdog at 0.
    task automatic test_timeout();
        logic [16:0] exp [7] = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_WAIT,
                                 E_HALT, E_HALT, E_HALT};
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            // Memory answering once halted must not wake the core.
            mem_ready = (i == 6);
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL timeout cycle %0d got %b expected %b", i, obs, exp[i]);
            else passed++;
            next_cycle();
        end
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== E_FETCH_WAIT) $display("FAIL halt_reset got %b expected %b", obs, E_FETCH_WAIT);
        else passed++;
        next_cycle();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH_GO) $display("FAIL halt_restart got %b expected %b", obs, E_FETCH_GO);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        logic [16:0] exp [4] = '{E_FETCH_GO, E_DECODE, E_EXEC_I, E_MEM_WR};
        opcode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3);
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL sw_abort cycle %0d got %b expected %b", i, obs, exp[i]);
            else passed++;
            if (i < 3) next_cycle();
        end
        // Mid-cycle reset: mem_wr must fall without waiting for a clock.
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_wr !== 1'b0 || obs !== E_FETCH_WAIT)
            $display("FAIL async_abort got %b expected %b", obs, E_FETCH_WAIT);
        else passed++;
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH_WAIT) $display("FAIL abort_release got %b expected %b", obs, E_FETCH_WAIT);
        else passed++;
        next_cycle();
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== E_FETCH_GO) $display("FAIL abort_refetch got %b expected %b", obs, E_FETCH_GO);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_stall();
        test_sw_addi();
        test_branch("beq_z1",      6'b000100, 1'b1, 1'b0, 1'b1);
        test_branch("beq_z0",      6'b000100, 1'b0, 1'b0, 1'b0);
        test_branch("bne_z1",      6'b000101, 1'b1, 1'b0, 1'b0);
        test_branch("bne_z0",      6'b000101, 1'b0, 1'b0, 1'b1);
        test_branch("bgtz_neg",    6'b000111, 1'b0, 1'b1, 1'b0);
        test_branch("bgtz_pos",    6'b000111, 1'b0, 1'b0, 1'b1);
        test_branch("bgtz_zero",   6'b000111, 1'b1, 1'b0, 1'b0);
        test_illegal();
        test_timeout();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_multicycle_control
`default_nettype wire
